// File: rtl/audio_pkg.sv
// Shared defaults and types for the audio frame FIFO slice.
package audio_pkg;

  localparam int AUDIO_SAMPLE_W = 8;
  localparam int AUDIO_NUM_CH   = 2;
  localparam int STATS_W        = 16;

  typedef enum logic {
    UR_ZERO = 1'b0,
    UR_HOLD = 1'b1
  } underrun_mode_e;

  function automatic underrun_mode_e ur_mode(input int hold);
    return (hold != 0) ? UR_HOLD : UR_ZERO;
  endfunction

endpackage

// File: rtl/audio_frame_fifo_if.sv
// Producer valid/ready and tick-paced consumer signals of the audio frame FIFO.
interface audio_frame_fifo_if
  import audio_pkg::*;
#(
  parameter int NUM_CH   = AUDIO_NUM_CH,
  parameter int SAMPLE_W = AUDIO_SAMPLE_W
);
  logic                       s_valid;
  logic                       s_ready;
  logic [NUM_CH*SAMPLE_W-1:0] s_data;
  logic                       m_tick;
  logic                       m_valid;
  logic [NUM_CH*SAMPLE_W-1:0] m_data;
  logic                       m_underrun;

  modport master (
    output s_valid, s_data, m_tick,
    input  s_ready, m_valid, m_data, m_underrun
  );

  modport slave (
    input  s_valid, s_data, m_tick,
    output s_ready, m_valid, m_data, m_underrun
  );
endinterface

// File: rtl/frame_ram.sv
// Simple dual-port frame store: synchronous write, registered read with enable.
module frame_ram #(
  parameter int DEPTH  = 1024,
  parameter int WIDTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              CLK,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rdata_reg;

  always_ff @(posedge CLK) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata_reg <= mem[raddr];
    end
  end

  assign rdata = rdata_reg;
endmodule

// File: rtl/audio_frame_fifo.sv
// Frame FIFO between the synth producer and the tick-paced DAC consumer.
// Define AFIFO_STATS_EN to build saturating underrun/drop counters; otherwise they read 0.
module audio_frame_fifo
  import audio_pkg::*;
#(
  parameter int DEPTH         = 1024,
  parameter int SAMPLE_W      = AUDIO_SAMPLE_W,
  parameter int NUM_CH        = AUDIO_NUM_CH,
  parameter int AF_THRESH     = DEPTH - 16,
  parameter int AE_THRESH     = 16,
  parameter int UNDERRUN_HOLD = 1
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   flush,
  audio_frame_fifo_if.slave      bus,
  output logic [$clog2(DEPTH):0] fill_level,
  output logic                   almost_full,
  output logic                   almost_empty,
  output logic [STATS_W-1:0]     underrun_cnt,
  output logic [STATS_W-1:0]     drop_cnt
);
  localparam int ADDR_W  = $clog2(DEPTH);
  localparam int FRAME_W = NUM_CH * SAMPLE_W;
  localparam underrun_mode_e UR_MODE = ur_mode(UNDERRUN_HOLD);

  typedef logic [ADDR_W:0]    lvl_t;
  typedef logic [STATS_W-1:0] stat_t;

  localparam lvl_t AF_LVL = lvl_t'(AF_THRESH);
  localparam lvl_t AE_LVL = lvl_t'(AE_THRESH);

  if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("audio_frame_fifo: DEPTH must be a power of two >= 4");
  end
  if (AF_THRESH > DEPTH || AE_THRESH >= DEPTH) begin : g_bad_thresh
    $error("audio_frame_fifo: watermark threshold out of range");
  end
  if (NUM_CH < 1 || NUM_CH > 8) begin : g_bad_ch
    $error("audio_frame_fifo: NUM_CH must be 1..8");
  end

  lvl_t               wr_ptr_reg, wr_ptr_next, rd_ptr_reg, rd_ptr_next;
  logic               full, empty, push, pop, underrun_ev;
  logic               use_ram_reg, m_valid_reg, m_underrun_reg;
  logic [FRAME_W-1:0] hold_reg, hold_next, ram_q, m_data;

  assign empty      = (wr_ptr_reg == rd_ptr_reg);
  assign full       = (wr_ptr_reg[ADDR_W-1:0] == rd_ptr_reg[ADDR_W-1:0]) &&
                      (wr_ptr_reg[ADDR_W] != rd_ptr_reg[ADDR_W]);
  assign fill_level = wr_ptr_reg - rd_ptr_reg;

  // Full refuses writes even when a pop lands in the same cycle.
  assign push        = bus.s_valid && !full && !flush && !RESET;
  assign pop         = bus.m_tick && !empty && !flush && !RESET;
  assign underrun_ev = bus.m_tick && empty && !flush && !RESET;

  always_comb begin
    wr_ptr_next = wr_ptr_reg + lvl_t'(push);
    rd_ptr_next = rd_ptr_reg + lvl_t'(pop);
  end

  frame_ram #(
    .DEPTH (DEPTH),
    .WIDTH (FRAME_W),
    .ADDR_W(ADDR_W)
  ) u_frame_ram (
    .CLK  (CLK),
    .we   (push),
    .waddr(wr_ptr_reg[ADDR_W-1:0]),
    .wdata(bus.s_data),
    .re   (pop),
    .raddr(rd_ptr_reg[ADDR_W-1:0]),
    .rdata(ram_q)
  );

  // Underrun fill: repeat the frame on the output or substitute silence.
  genvar gi;
  for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
    assign hold_next[gi*SAMPLE_W +: SAMPLE_W] =
      (UR_MODE == UR_HOLD) ? m_data[gi*SAMPLE_W +: SAMPLE_W] : '0;
  end

  always_ff @(posedge CLK) begin
    if (RESET || flush) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      m_valid_reg    <= 1'b0;
      m_underrun_reg <= 1'b0;
      use_ram_reg    <= 1'b0;
      hold_reg       <= '0;
    end else begin
      wr_ptr_reg     <= wr_ptr_next;
      rd_ptr_reg     <= rd_ptr_next;
      m_valid_reg    <= bus.m_tick;
      m_underrun_reg <= underrun_ev;
      if (pop) begin
        use_ram_reg <= 1'b1;
      end else if (underrun_ev) begin
        use_ram_reg <= 1'b0;
        hold_reg    <= hold_next;
      end
    end
  end

  // The RAM read register carries delivered frames; hold_reg covers underrun/clear.
  assign m_data         = use_ram_reg ? ram_q : hold_reg;
  assign bus.m_data     = m_data;
  assign bus.m_valid    = m_valid_reg;
  assign bus.m_underrun = m_underrun_reg;
  assign bus.s_ready    = !full;
  assign almost_full    = (fill_level >= AF_LVL);
  assign almost_empty   = (fill_level <= AE_LVL);

`ifdef AFIFO_STATS_EN
  stat_t underrun_cnt_reg, drop_cnt_reg;

  always_ff @(posedge CLK) begin
    if (RESET || flush) begin
      underrun_cnt_reg <= '0;
      drop_cnt_reg     <= '0;
    end else begin
      if (underrun_ev && underrun_cnt_reg != '1) begin
        underrun_cnt_reg <= underrun_cnt_reg + stat_t'(1);
      end
      if (bus.s_valid && full && drop_cnt_reg != '1) begin
        drop_cnt_reg <= drop_cnt_reg + stat_t'(1);
      end
    end
  end

  assign underrun_cnt = underrun_cnt_reg;
  assign drop_cnt     = drop_cnt_reg;
`else
  assign underrun_cnt = '0;
  assign drop_cnt     = '0;
`endif

endmodule

// File: tb/tb_audio_frame_fifo.sv
// Randomised scoreboard bench for audio_frame_fifo; one instance per underrun fill mode.
module tb_audio_frame_fifo;
  import audio_pkg::*;

  localparam int DEPTH = 64;
  localparam int SW    = 8;
  localparam int NCH   = 2;
  localparam int FW    = SW * NCH;
  localparam int AF    = 48;
  localparam int AE    = 16;
`ifdef AFIFO_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  typedef struct {
    int          due;
    bit          sil;
    bit          ur;
    logic [FW-1:0] d0;
    logic [FW-1:0] d1;
  } exp_t;

  logic          CLK = 1'b0;
  logic          RESET = 1'b1;
  logic          flush = 1'b0;
  logic          s_valid = 1'b0;
  logic [FW-1:0] s_data = '0;
  logic          m_tick = 1'b0;

  logic [6:0]  fill0, fill1;
  logic        af0, af1, ae0, ae1;
  logic [15:0] uc0, uc1, dc0, dc1;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  bit chk_en = 1'b0;
  bit mon_en = 1'b0;

  logic [FW-1:0] mq[$];
  exp_t          eq[$];
  exp_t          mon_e;
  logic [FW-1:0] last1 = '0;
  logic [FW-1:0] cur0 = '0;
  logic [FW-1:0] cur1 = '0;
  int            ur_cnt = 0;
  int            dr_cnt = 0;

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  audio_frame_fifo_if #(.NUM_CH(NCH), .SAMPLE_W(SW)) bus0 ();
  audio_frame_fifo_if #(.NUM_CH(NCH), .SAMPLE_W(SW)) bus1 ();

  assign bus0.s_valid = s_valid;
  assign bus0.s_data  = s_data;
  assign bus0.m_tick  = m_tick;
  assign bus1.s_valid = s_valid;
  assign bus1.s_data  = s_data;
  assign bus1.m_tick  = m_tick;

  audio_frame_fifo #(
    .DEPTH(DEPTH), .SAMPLE_W(SW), .NUM_CH(NCH),
    .AF_THRESH(AF), .AE_THRESH(AE), .UNDERRUN_HOLD(0)
  ) dut0 (
    .CLK(CLK), .RESET(RESET), .flush(flush), .bus(bus0.slave),
    .fill_level(fill0), .almost_full(af0), .almost_empty(ae0),
    .underrun_cnt(uc0), .drop_cnt(dc0)
  );

  audio_frame_fifo #(
    .DEPTH(DEPTH), .SAMPLE_W(SW), .NUM_CH(NCH),
    .AF_THRESH(AF), .AE_THRESH(AE), .UNDERRUN_HOLD(1)
  ) dut1 (
    .CLK(CLK), .RESET(RESET), .flush(flush), .bus(bus1.slave),
    .fill_level(fill1), .almost_full(af1), .almost_empty(ae1),
    .underrun_cnt(uc1), .drop_cnt(dc1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic check_status(input string tag, input logic [6:0] fl, input logic rdy,
                              input logic af, input logic ae,
                              input logic [15:0] uc, input logic [15:0] dc);
    int n;
    n = mq.size();
    chk({tag, "_fill"}, 32'(fl), 32'(n));
    chk({tag, "_s_ready"}, 32'(rdy), 32'(n < DEPTH));
    chk({tag, "_almost_full"}, 32'(af), 32'(n >= AF));
    chk({tag, "_almost_empty"}, 32'(ae), 32'(n <= AE));
    chk({tag, "_underrun_cnt"}, 32'(uc), STATS ? 32'(ur_cnt) : 32'd0);
    chk({tag, "_drop_cnt"}, 32'(dc), STATS ? 32'(dr_cnt) : 32'd0);
  endtask

  // One clock of stimulus; the reference model advances by the same events.
  task automatic step(input bit rst, input bit fl, input bit sv, input logic [FW-1:0] d,
                      input bit tk);
    logic [FW-1:0] f;
    bit            full_now;
    @(negedge CLK);
    if (chk_en) begin
      check_status("dut0", fill0, bus0.s_ready, af0, ae0, uc0, dc0);
      check_status("dut1", fill1, bus1.s_ready, af1, ae1, uc1, dc1);
    end
    RESET   = rst;
    flush   = fl;
    s_valid = sv;
    s_data  = d;
    m_tick  = tk;
    if (rst || fl) begin
      mq.delete();
      last1  = '0;
      ur_cnt = 0;
      dr_cnt = 0;
      if (mon_en) eq.push_back('{cyc + 1, 1'b1, 1'b0, '0, '0});
    end else begin
      full_now = (mq.size() == DEPTH);
      if (tk) begin
        if (mq.size() == 0) begin
          if (ur_cnt < 65535) ur_cnt++;
          eq.push_back('{cyc + 1, 1'b0, 1'b1, '0, last1});
        end else begin
          f = mq.pop_front();
          last1 = f;
          eq.push_back('{cyc + 1, 1'b0, 1'b0, f, f});
        end
      end
      if (sv) begin
        if (full_now) begin
          if (dr_cnt < 65535) dr_cnt++;
        end else begin
          mq.push_back(d);
        end
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, '0, 0);
  endtask

  // Monitor: compares every output pulse (or its absence) against the expectation queue.
  always @(negedge CLK) begin
    if (mon_en) begin
      if (eq.size() > 0 && eq[0].due < cyc) begin
        mon_e = eq.pop_front();
        chk("late_event", 32'(mon_e.due), 32'(cyc));
      end
      if (eq.size() > 0 && eq[0].due == cyc) begin
        mon_e = eq.pop_front();
        if (mon_e.sil) begin
          chk("clear_pulses", {28'd0, bus0.m_valid, bus0.m_underrun, bus1.m_valid, bus1.m_underrun}, 32'd0);
          chk("clear_data0", 32'(bus0.m_data), 32'd0);
          chk("clear_data1", 32'(bus1.m_data), 32'd0);
          cur0 = '0;
          cur1 = '0;
        end else begin
          chk("tick_valid", {30'd0, bus0.m_valid, bus1.m_valid}, 32'd3);
          chk("tick_underrun", {30'd0, bus0.m_underrun, bus1.m_underrun}, {30'd0, mon_e.ur, mon_e.ur});
          chk("tick_data0", 32'(bus0.m_data), 32'(mon_e.d0));
          chk("tick_data1", 32'(bus1.m_data), 32'(mon_e.d1));
          cur0 = mon_e.d0;
          cur1 = mon_e.d1;
        end
      end else begin
        chk("idle_pulses", {28'd0, bus0.m_valid, bus0.m_underrun, bus1.m_valid, bus1.m_underrun}, 32'd0);
        chk("hold_data0", 32'(bus0.m_data), 32'(cur0));
        chk("hold_data1", 32'(bus1.m_data), 32'(cur1));
      end
    end
  end

  initial begin
    int sent;
    logic [FW-1:0] rd;
    step(1, 0, 0, '0, 0);
    step(1, 0, 0, '0, 0);
    eq.delete();
    chk_en = 1'b1;
    mon_en = 1'b1;

    // Three frames in, three ticks out.
    step(0, 0, 1, 16'h0101, 0);
    step(0, 0, 1, 16'h0202, 0);
    step(0, 0, 1, 16'h0303, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, '0, 1);
    idle(2);

    // Underrun on empty after 0x0303, twice.
    step(0, 0, 0, '0, 1);
    idle(1);
    step(0, 0, 0, '0, 1);
    idle(1);

    // Write into empty together with a tick, then collect it.
    step(0, 0, 1, 16'h0A0A, 1);
    idle(1);
    step(0, 0, 0, '0, 1);
    idle(1);

    // Fill to capacity, overrun for five cycles, then a refused write with a pop.
    for (int i = 0; i < DEPTH; i++) step(0, 0, 1, FW'($urandom), 0);
    for (int i = 0; i < 5; i++) step(0, 0, 1, FW'($urandom), 0);
    step(0, 0, 1, 16'hBEEF, 1);
    idle(2);

    // Flush with ten frames stored and a simultaneous tick and write.
    while (mq.size() > 10) step(0, 0, 0, '0, 1);
    idle(1);
    step(0, 1, 1, 16'h5A5A, 1);
    idle(2);

    // Wrap-around stream of sequential frames with random interleaving.
    sent = 0;
    for (int it = 0; it < 5000 && sent < 3 * DEPTH; it++) begin
      bit sv, tk;
      sv = ($urandom_range(99) < 60);
      tk = ($urandom_range(99) < 50);
      if (sv && mq.size() < DEPTH) begin
        step(0, 0, 1, FW'(sent + 1), tk);
        sent++;
      end else begin
        step(0, 0, sv, FW'(sent + 1), tk);
      end
    end
    chk("wrap_stream_done", 32'(sent >= 3 * DEPTH), 32'd1);
    while (mq.size() > 0) step(0, 0, 0, '0, 1);

    // Bursty phases reaching full and empty, with occasional flush.
    for (int i = 0; i < 200; i++) step(0, 0, $urandom_range(99) < 90, FW'($urandom), $urandom_range(99) < 20);
    for (int i = 0; i < 200; i++) step(0, 0, $urandom_range(99) < 20, FW'($urandom), $urandom_range(99) < 90);
    for (int i = 0; i < 300; i++) begin
      rd = FW'($urandom);
      step(0, $urandom_range(99) < 2, $urandom_range(99) < 55, rd, $urandom_range(99) < 50);
    end

    // Reset mid-stream discards contents.
    for (int i = 0; i < 20; i++) step(0, 0, 1, FW'($urandom), 0);
    step(1, 0, 1, 16'h1234, 1);
    idle(3);
    step(0, 0, 0, '0, 1);
    idle(3);

    chk("pending_events", 32'(eq.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/audio_frame_fifo.md
Name: audio_frame_fifo

Overview:
Parametrised multi-channel successor to the single-stream audio FIFO. It buffers complete audio frames (NUM_CH samples each) between the note/synth producer and the sample-rate-paced DAC/PWM consumer. Additions over the earlier block:
- valid/ready producer handshake
- tick-driven consumer that always gets a sample
- defined underrun fill policy
- almost-full/almost-empty watermarks
- synchronous flush

Parameters:
DEPTH, 1024, frame capacity; power of two, >= 4
SAMPLE_W, 8, bits per channel sample
NUM_CH, 2, channels per frame (1..8)
AF_THRESH, DEPTH-16, almost_full asserted when fill_level >= AF_THRESH
AE_THRESH, 16, almost_empty asserted when fill_level <= AE_THRESH
UNDERRUN_HOLD, 1, 1 = repeat last delivered frame on underrun; 0 = output zero frame

Ports:
CLK  in  1  clock
RESET  in  1  synchronous, active-high reset
flush  in  1  synchronous clear of contents
s_valid  in  1  producer frame valid
s_ready  out  1  FIFO can accept a frame (= !full)
s_data  in  NUM_CH*SAMPLE_W  frame; channel 0 in LSBs
m_tick  in  1  one-cycle sample-rate request
m_valid  out  1  m_data updated this cycle (pulse)
m_data  out  NUM_CH*SAMPLE_W  frame to consumer
m_underrun  out  1  pulse: m_tick found FIFO empty
fill_level  out  $clog2(DEPTH)+1  frames stored
almost_full  out  1  watermark
almost_empty  out  1  watermark
underrun_cnt  out  16  saturating underrun count (AFIFO_STATS_EN)
drop_cnt  out  16  saturating count of s_valid && !s_ready cycles (AFIFO_STATS_EN)

Behaviour:
Pointers and write:
- Pointers are ADDR_W+1 bits with a wrap bit.
- full = same address, different wrap bit.
- empty = pointers equal.
- fill_level = wr_ptr - rd_ptr, modulo 2^(ADDR_W+1).
- s_ready, full, empty, fill_level, almost_full and almost_empty are combinational from the pointers.
- A write occurs when s_valid && s_ready; wr_ptr increments by 1.
- A write is refused while full, even if m_tick pops in the same cycle. Producer retries next cycle.
- s_valid may drop without a transfer; no stickiness is required.

Read:
- m_tick with !empty: next cycle m_data = mem[rd_addr], m_valid = 1, rd_ptr++.
- m_tick with empty: next cycle m_valid = 1, m_underrun = 1, rd_ptr unchanged. m_data = previous m_data if UNDERRUN_HOLD=1, else all zeros.
- Latency is 1 cycle from m_tick to m_valid.
- m_valid and m_underrun are single-cycle pulses.
- m_data holds between ticks.

Simultaneous events:
- Write into an empty FIFO in the same cycle as m_tick: the read sees empty (underrun); the written frame is delivered on the next tick.
- Read and write in the same non-full, non-empty cycle: fill_level is unchanged.

Flush:
- Pointers go to 0 next cycle and m_data is zeroed.
- In-cycle write and read are ignored; no m_valid or m_underrun is generated.
- Flush has priority over everything except RESET.

RESET:
- Pointers, m_data, m_valid, m_underrun and the counters clear to 0.
- After reset: s_ready = 1, empty, almost_empty = 1, almost_full = 0, fill_level = 0.
- RESET mid-stream discards all contents. Memory contents are not reset.

Width rules:
- Thresholds are compared as unsigned values at fill_level width.
- Elaboration fails if AF_THRESH > DEPTH or AE_THRESH >= DEPTH.

Optional Feature:
AFIFO_STATS_EN
- Defined: underrun_cnt increments on each m_underrun pulse, and drop_cnt on each s_valid && !s_ready cycle. Both saturate at 16'hFFFF and clear on RESET or flush.
- Undefined: no counter logic is built; both ports are tied to 0.

Decomposition:
- Package audio_pkg holds:
  - AUDIO_SAMPLE_W and AUDIO_NUM_CH defaults
  - STATS_W = 16
  - typedef enum {UR_ZERO, UR_HOLD} underrun_mode_e, mapped to UNDERRUN_HOLD
- Sub-module frame_ram: simple dual-port RAM, DEPTH x NUM_CH*SAMPLE_W.
  - Write port: synchronous.
  - Read port: registered, enable = pop.
  - Keeps the storage inferable as BRAM.
- Pointer, flag and underrun logic stay in audio_frame_fifo.

Test Plan:
- Reset, then write frames 0x0101, 0x0202, 0x0303 (NUM_CH=2, SAMPLE_W=8), then 3 ticks: m_data = 0x0101, 0x0202, 0x0303, each 1 cycle after its tick; fill_level goes 3 -> 0.
- Fill to DEPTH: s_ready = 0, almost_full = 1. Extra s_valid for 5 cycles: drop_cnt = 5 (stats enabled). One tick then restores s_ready = 1.
- Tick on empty after last frame 0x0303: UNDERRUN_HOLD=1 gives m_data = 0x0303 with m_underrun = 1; UNDERRUN_HOLD=0 gives m_data = 0x0000. rd_ptr is unchanged in both cases.
- Write into an empty FIFO together with m_tick: m_underrun = 1 and fill_level = 1. The next tick delivers the written frame.
- Wrap-around: stream 3*DEPTH frames with an interleaved tick pattern. Output equals the input sequence and fill_level never exceeds DEPTH.
- Flush with fill_level = 10 and a simultaneous tick and write: next cycle fill_level = 0, m_data = 0, no m_valid pulse, counters cleared.
